dma_sram_slave: RTL and testbench
=================================

Name: dma_sram_slave

Overview:
- Synthesizable word-wide SRAM slave that terminates one DMA master port (dma_*_p1 / dma_*_p2 bus) directly downstream of dma_top.
- Decodes the 16-bit byte address against a base window, applies byte write enables, inserts programmable wait states and signals decode errors via resp.
- Serves as the real memory target behind either DMA port, in silicon or in the bench.

Parameters:
- AW, 10, word-address width; depth = 2^AW 16-bit words.
- BASE_ADDR, 16'h0000, byte base address of the window; must be aligned to 2^(AW+1).
- WAIT_STATES, 2, extra cycles inserted before ready (0..15).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dma_addr  input  16  byte address of the request.
- dma_en  input  1  request strobe; master holds it and addr/wen/din stable until ready.
- dma_wen  input  2  byte write enables; [0]=low byte, [1]=high byte; 2'b00 = read.
- dma_din  input  16  write data.
- dma_ready  output  1  one-cycle completion pulse.
- dma_dout  output  16  read data; valid only while dma_ready=1, otherwise 0.
- dma_resp  output  1  error flag; valid with dma_ready; 1 = error.

Behaviour:
- Reset: dma_ready=0, dma_dout=0, dma_resp=0, FSM=IDLE, wait counter=0. Memory array is not reset; contents survive reset.
- FSM states:
  - IDLE: when dma_en=1, latch addr/wen/din, compute err, load cnt=WAIT_STATES, go to WAIT (or RESP if WAIT_STATES=0).
  - WAIT: decrement cnt; go to RESP on the cycle cnt reaches 0.
  - RESP: dma_ready=1 for exactly one cycle, then return to IDLE.
- Latency: request sampled at edge N gives dma_ready high in cycle N+1+WAIT_STATES.
- Back-to-back requests are accepted no earlier than the edge after the RESP cycle, giving a one-cycle bubble. dma_en held in the RESP cycle is treated as the old request and ignored.
- Decode: err=1 if addr[0]=1 (misaligned) or addr[15:AW+1] != BASE_ADDR[15:AW+1]. Word index = addr[AW:1].
- Write (wen!=0, err=0): memory updated once, at the edge entering RESP; only enabled bytes change; dma_dout=0 in RESP.
- Read (wen=0, err=0): dma_dout = mem[index], registered so it is valid in RESP.
- Error: no memory update; dma_dout=0; dma_resp=1 in RESP.
- dma_en deasserted during WAIT (protocol violation): the transaction still completes as latched.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous) and the FSM goes to IDLE. A pending write whose commit edge has not occurred is discarded.
- The address window wraps neither inside nor past the top; any address beyond BASE+2^(AW+1)-1 is an error.

Optional Feature:
- DMA_SRAM_SLAVE_ERR_INJ_EN.
- Defined: adds input port err_inj (1 bit), sampled with the request in IDLE. If err_inj=1, the transaction completes with dma_resp=1, dma_dout=0 and no write, at normal latency.
- Undefined: port absent; dma_resp is driven only by decode errors.

Test Plan:
- Reset: assert reset mid-WAIT -> dma_ready, dma_resp and dma_dout go 0 at once; FSM IDLE; memory preserved on later readback.
- Full write then read: write 16'hA5C3, wen=2'b11, addr=BASE+16'h0010; read it back -> dma_dout=16'hA5C3, dma_resp=0, dma_ready 3 cycles after acceptance (WAIT_STATES=2).
- Byte enables: preload 16'h1234; write 16'hABCD with wen=2'b01 -> readback 16'h12CD; then wen=2'b10 with 16'h56EF -> readback 16'h56CD.
- Decode error: read at addr=16'h0801 (misaligned) and at BASE+16'h0800 (AW=10, out of range) -> dma_resp=1, dma_dout=0; a write to the out-of-range address leaves memory unchanged.
- Latency sweep: WAIT_STATES=0 -> dma_ready at N+1; WAIT_STATES=15 -> dma_ready at N+16. A request held high through RESP is not accepted twice (exactly one ready pulse).
- With DMA_SRAM_SLAVE_ERR_INJ_EN: write with err_inj=1 -> dma_resp=1 and the target word keeps its old value; without the macro, the same write succeeds.

Source files
------------

// File: rtl/dma_sram_if.sv
// DMA master-to-SRAM-slave request/response bus.
// The master drives address, strobe, byte enables and write data.
// The slave answers with a one-cycle ready pulse, read data and an error flag.
interface dma_sram_if;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_wen;
  logic [15:0] dma_din;
  logic        dma_ready;
  logic [15:0] dma_dout;
  logic        dma_resp;

  modport master (
    output dma_addr, dma_en, dma_wen, dma_din,
    input  dma_ready, dma_dout, dma_resp
  );

  modport slave (
    input  dma_addr, dma_en, dma_wen, dma_din,
    output dma_ready, dma_dout, dma_resp
  );
endinterface

// File: rtl/dma_sram_slave.sv
// Word-wide SRAM slave terminating one DMA master port.
// - Decodes the 16-bit byte address against a window of 2^(AW+1) bytes at
//   BASE_ADDR (BASE_ADDR must be aligned to the window size).
// - Misaligned or out-of-window requests complete with dma_resp=1, no write.
// - WAIT_STATES (0..15) extra cycles are inserted before the ready pulse.
// - Optional macro DMA_SRAM_SLAVE_ERR_INJ_EN adds an err_inj input that
//   forces the request sampled with it to complete as an error.
// The memory array is not reset; its contents survive reset.
module dma_sram_slave #(
  parameter int          AW          = 10,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic      clk,
  input  logic      reset,
`ifdef DMA_SRAM_SLAVE_ERR_INJ_EN
  input  logic      err_inj,
`endif
  dma_sram_if.slave dma
);

  localparam int         DEPTH = 1 << AW;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_wen;
  logic [15:0]   r_din;
  logic          r_err;
  logic          r_ready;
  logic [15:0]   r_dout;
  logic          r_resp;
  logic [15:0]   r_mem [DEPTH];

  logic          w_dec_err;
  logic          w_req_err;
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_wen;
  logic [15:0]   w_din;
  logic          w_err;

  // Misaligned byte address, or upper bits outside the window (no wrap).
  assign w_dec_err = dma.dma_addr[0] |
                     (dma.dma_addr[15:AW+1] != BASE_ADDR[15:AW+1]);

`ifdef DMA_SRAM_SLAVE_ERR_INJ_EN
  assign w_req_err = w_dec_err | err_inj;
`else
  assign w_req_err = w_dec_err;
`endif

  assign w_accept     = (r_state == S_IDLE) && dma.dma_en;
  assign w_enter_resp = (w_accept && (WS == 4'd0)) ||
                        ((r_state == S_WAIT) && (r_cnt <= 4'd1));

  // With zero wait states RESP is entered straight from IDLE, before the
  // request has been latched, so the live bus feeds the commit/read path.
  assign w_idx = (r_state == S_IDLE) ? dma.dma_addr[AW:1] : r_idx;
  assign w_wen = (r_state == S_IDLE) ? dma.dma_wen        : r_wen;
  assign w_din = (r_state == S_IDLE) ? dma.dma_din        : r_din;
  assign w_err = (r_state == S_IDLE) ? w_req_err          : r_err;

  // A write lands exactly once, on the edge entering RESP; a reset that is
  // already asserted cancels it.
  assign w_commit = w_enter_resp && !reset && !w_err && (w_wen != 2'b00);

  // Request FSM plus registered ready/resp/dout.
  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wen   <= 2'b00;
      r_din   <= 16'h0000;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
      r_dout  <= 16'h0000;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dma.dma_en) begin
            r_idx   <= dma.dma_addr[AW:1];
            r_wen   <= dma.dma_wen;
            r_din   <= dma.dma_din;
            r_err   <= w_req_err;
            r_cnt   <= WS;
            r_state <= (WS == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_RESP;
        end
        S_RESP: begin
          // dma_en still high here belongs to the request just served.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        r_ready <= 1'b1;
        r_resp  <= w_err;
        r_dout  <= (!w_err && (w_wen == 2'b00)) ? r_mem[w_idx] : 16'h0000;
      end else begin
        r_ready <= 1'b0;
        r_resp  <= 1'b0;
        r_dout  <= 16'h0000;
      end
    end
  end

  // Byte-masked write into the array.
  // NOTE: the array deliberately has no reset; contents must survive it and it must map to RAM.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (w_wen[0]) r_mem[w_idx][7:0]  <= w_din[7:0];
      if (w_wen[1]) r_mem[w_idx][15:8] <= w_din[15:8];
    end
  end

  assign dma.dma_ready = r_ready;
  assign dma.dma_dout  = r_dout;
  assign dma.dma_resp  = r_resp;

endmodule

// File: tb/tb_dma_sram_slave.sv
// Directed bench for dma_sram_slave: three instances with 2, 0 and 15 wait
// states share one stimulus bus; only the selected instance sees dma_en.
module tb_dma_sram_slave;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] t_addr;
  logic [15:0] t_din;
  logic [1:0]  t_wen;
  logic [2:0]  t_en;
  logic        t_inj;

  int checks = 0;
  int errors = 0;

  dma_sram_if bus2 ();
  dma_sram_if bus0 ();
  dma_sram_if bus15 ();

  assign bus2.dma_addr  = t_addr;
  assign bus2.dma_wen   = t_wen;
  assign bus2.dma_din   = t_din;
  assign bus2.dma_en    = t_en[0];
  assign bus0.dma_addr  = t_addr;
  assign bus0.dma_wen   = t_wen;
  assign bus0.dma_din   = t_din;
  assign bus0.dma_en    = t_en[1];
  assign bus15.dma_addr = t_addr;
  assign bus15.dma_wen  = t_wen;
  assign bus15.dma_din  = t_din;
  assign bus15.dma_en   = t_en[2];

  logic [2:0]  w_ready;
  logic [2:0]  w_resp;
  logic [15:0] w_dout [3];
  assign w_ready   = {bus15.dma_ready, bus0.dma_ready, bus2.dma_ready};
  assign w_resp    = {bus15.dma_resp,  bus0.dma_resp,  bus2.dma_resp};
  assign w_dout[0] = bus2.dma_dout;
  assign w_dout[1] = bus0.dma_dout;
  assign w_dout[2] = bus15.dma_dout;

  dma_sram_slave #(.AW(10), .BASE_ADDR(16'h0000), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset),
`ifdef DMA_SRAM_SLAVE_ERR_INJ_EN
    .err_inj(t_inj),
`endif
    .dma(bus2)
  );

  dma_sram_slave #(.AW(10), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
`ifdef DMA_SRAM_SLAVE_ERR_INJ_EN
    .err_inj(t_inj),
`endif
    .dma(bus0)
  );

  dma_sram_slave #(.AW(10), .BASE_ADDR(16'h0000), .WAIT_STATES(15)) u_dut15 (
    .clk(clk), .reset(reset),
`ifdef DMA_SRAM_SLAVE_ERR_INJ_EN
    .err_inj(t_inj),
`endif
    .dma(bus15)
  );

  // One transaction on instance sel. lat = negedges after the accepting edge
  // until ready is seen (= WAIT_STATES+1). dma_en is held through RESP unless
  // drop_en, then released; pulses counts every ready seen afterwards too.
  task automatic xfer(input int sel, input logic [15:0] addr, input logic [1:0] wen,
                      input logic [15:0] din, input logic inj, input logic drop_en,
                      output int lat, output logic [15:0] dout, output logic resp,
                      output int pulses);
    @(negedge clk);
    t_addr = addr; t_wen = wen; t_din = din; t_inj = inj;
    t_en = 3'b000; t_en[sel] = 1'b1;
    @(posedge clk);
    if (drop_en) begin #1; t_en = 3'b000; end
    lat = 0; dout = 16'h0000; resp = 1'b0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (w_ready[sel]) begin
        lat = k; dout = w_dout[sel]; resp = w_resp[sel];
        break;
      end
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL ready_timeout: inst %0d addr %h got no ready within 40 cycles", sel, addr);
    end
    checks++;
    pulses = (lat != 0) ? 1 : 0;
    @(posedge clk); #1;
    t_en = 3'b000; t_wen = 2'b00; t_inj = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (w_ready[sel]) pulses++;
    end
  endtask

  task automatic test_reset_state();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (bus2.dma_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus2.dma_ready); end
    checks++;
    if (bus2.dma_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b expected 0", bus2.dma_resp); end
    checks++;
    if (bus2.dma_dout !== 16'h0000) begin errors++; $display("FAIL rst_dout: got %h expected 0000", bus2.dma_dout); end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, pl; logic [15:0] d; logic r;
    xfer(0, 16'h0010, 2'b11, 16'hA5C3, 1'b0, 1'b0, lat, d, r, pl);
    if (lat !== 3) begin errors++; $display("FAIL wr_lat: got %0d expected 3", lat); end
    checks++;
    if (r !== 1'b0 || d !== 16'h0000) begin errors++; $display("FAIL wr_resp: got resp %b dout %h expected 0 0000", r, d); end
    checks++;
    xfer(0, 16'h0010, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'hA5C3) begin errors++; $display("FAIL rd_data: got %h expected a5c3", d); end
    checks++;
    if (r !== 1'b0) begin errors++; $display("FAIL rd_resp: got %b expected 0", r); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_lat: got %0d expected 3", lat); end
    checks++;
    if (pl !== 1) begin errors++; $display("FAIL rd_pulses: got %0d expected 1", pl); end
    checks++;
  endtask

  task automatic test_byte_en();
    int lat, pl; logic [15:0] d; logic r;
    xfer(0, 16'h0030, 2'b11, 16'h1234, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h0030, 2'b01, 16'hABCD, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h0030, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'h12CD) begin errors++; $display("FAIL be_low: got %h expected 12cd", d); end
    checks++;
    xfer(0, 16'h0030, 2'b10, 16'h56EF, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h0030, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'h56CD) begin errors++; $display("FAIL be_high: got %h expected 56cd", d); end
    checks++;
  endtask

  task automatic test_decode_err();
    int lat, pl; logic [15:0] d; logic r;
    xfer(0, 16'h0000, 2'b11, 16'h1111, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h0801, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (r !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL err_0801: got resp %b dout %h expected 1 0000", r, d); end
    checks++;
    xfer(0, 16'h0011, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (r !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL err_misalign: got resp %b dout %h expected 1 0000", r, d); end
    checks++;
    xfer(0, 16'h0800, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (r !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL err_range: got resp %b dout %h expected 1 0000", r, d); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL err_lat: got %0d expected 3", lat); end
    checks++;
    xfer(0, 16'h0800, 2'b11, 16'hBEEF, 1'b0, 1'b0, lat, d, r, pl);
    if (r !== 1'b1) begin errors++; $display("FAIL err_wr_resp: got %b expected 1", r); end
    checks++;
    xfer(0, 16'h0011, 2'b11, 16'hDEAD, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'h1111) begin errors++; $display("FAIL err_no_wrap: got %h expected 1111", d); end
    checks++;
    xfer(0, 16'h0010, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'hA5C3) begin errors++; $display("FAIL err_misalign_wr: got %h expected a5c3", d); end
    checks++;
    xfer(0, 16'h07FE, 2'b11, 16'h7777, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h07FE, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (r !== 1'b0 || d !== 16'h7777) begin errors++; $display("FAIL top_word: got resp %b dout %h expected 0 7777", r, d); end
    checks++;
  endtask

  // Reset while the slave is in RESP: outputs must drop without a clock edge.
  task automatic reset_in_resp(input logic [15:0] addr, input logic [15:0] exp_d, input logic exp_r);
    int seen = 0;
    @(negedge clk);
    t_addr = addr; t_wen = 2'b00; t_din = 16'h0000; t_en = 3'b001;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus2.dma_ready) begin seen = 1; break; end
    end
    if (seen == 0 || bus2.dma_dout !== exp_d || bus2.dma_resp !== exp_r) begin
      errors++;
      $display("FAIL resp_before_rst: got ready %0d dout %h resp %b expected 1 %h %b", seen, bus2.dma_dout, bus2.dma_resp, exp_d, exp_r);
    end
    checks++;
    reset = 1'b1; #1;
    if (bus2.dma_ready !== 1'b0 || bus2.dma_dout !== 16'h0000 || bus2.dma_resp !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got ready %b dout %h resp %b expected 0 0000 0", bus2.dma_ready, bus2.dma_dout, bus2.dma_resp);
    end
    checks++;
    t_en = 3'b000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, pl; logic [15:0] d; logic r;
    xfer(0, 16'h0020, 2'b11, 16'h5A5A, 1'b0, 1'b0, lat, d, r, pl);
    @(negedge clk);
    t_addr = 16'h0020; t_wen = 2'b11; t_din = 16'hFFFF; t_en = 3'b001;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    if (bus2.dma_ready !== 1'b0 || bus2.dma_resp !== 1'b0 || bus2.dma_dout !== 16'h0000) begin
      errors++;
      $display("FAIL rst_wait: got ready %b resp %b dout %h expected 0 0 0000", bus2.dma_ready, bus2.dma_resp, bus2.dma_dout);
    end
    checks++;
    @(negedge clk);
    t_en = 3'b000; t_wen = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    xfer(0, 16'h0020, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'h5A5A) begin errors++; $display("FAIL rst_discard: got %h expected 5a5a", d); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rst_idle_lat: got %0d expected 3", lat); end
    checks++;
    reset_in_resp(16'h0020, 16'h5A5A, 1'b0);
    reset_in_resp(16'h0801, 16'h0000, 1'b1);
    xfer(0, 16'h0010, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'hA5C3) begin errors++; $display("FAIL rst_mem_kept: got %h expected a5c3", d); end
    checks++;
  endtask

  task automatic test_latency();
    int lat, pl; logic [15:0] d; logic r;
    xfer(1, 16'h0002, 2'b11, 16'hC0DE, 1'b0, 1'b0, lat, d, r, pl);
    if (lat !== 1) begin errors++; $display("FAIL ws0_wr_lat: got %0d expected 1", lat); end
    checks++;
    if (pl !== 1) begin errors++; $display("FAIL ws0_pulses: got %0d expected 1", pl); end
    checks++;
    xfer(1, 16'h0002, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'hC0DE || lat !== 1) begin errors++; $display("FAIL ws0_rd: got dout %h lat %0d expected c0de 1", d, lat); end
    checks++;
    xfer(2, 16'h0004, 2'b11, 16'hF00D, 1'b0, 1'b0, lat, d, r, pl);
    if (lat !== 16) begin errors++; $display("FAIL ws15_wr_lat: got %0d expected 16", lat); end
    checks++;
    xfer(2, 16'h0004, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'hF00D || lat !== 16) begin errors++; $display("FAIL ws15_rd: got dout %h lat %0d expected f00d 16", d, lat); end
    checks++;
    if (pl !== 1) begin errors++; $display("FAIL ws15_pulses: got %0d expected 1", pl); end
    checks++;
  endtask

  task automatic test_en_drop();
    int lat, pl; logic [15:0] d; logic r;
    xfer(0, 16'h0060, 2'b11, 16'h3C3C, 1'b0, 1'b1, lat, d, r, pl);
    if (lat !== 3 || r !== 1'b0) begin errors++; $display("FAIL drop_done: got lat %0d resp %b expected 3 0", lat, r); end
    checks++;
    xfer(0, 16'h0060, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== 16'h3C3C) begin errors++; $display("FAIL drop_data: got %h expected 3c3c", d); end
    checks++;
  endtask

  task automatic test_err_inj();
    int lat, pl; logic [15:0] d; logic r;
    logic        exp_r;
    logic [15:0] exp_d;
`ifdef DMA_SRAM_SLAVE_ERR_INJ_EN
    exp_r = 1'b1; exp_d = 16'h2222;
`else
    exp_r = 1'b0; exp_d = 16'h9999;
`endif
    xfer(0, 16'h0050, 2'b11, 16'h2222, 1'b0, 1'b0, lat, d, r, pl);
    xfer(0, 16'h0050, 2'b11, 16'h9999, 1'b1, 1'b0, lat, d, r, pl);
    if (r !== exp_r || lat !== 3) begin errors++; $display("FAIL inj_resp: got resp %b lat %0d expected %b 3", r, lat, exp_r); end
    checks++;
    xfer(0, 16'h0050, 2'b00, 16'h0000, 1'b0, 1'b0, lat, d, r, pl);
    if (d !== exp_d) begin errors++; $display("FAIL inj_data: got %h expected %h", d, exp_d); end
    checks++;
  endtask

  initial begin
    t_addr = 16'h0000; t_din = 16'h0000; t_wen = 2'b00; t_en = 3'b000; t_inj = 1'b0;
    test_reset_state();
    test_write_read();
    test_byte_en();
    test_decode_err();
    test_reset_mid();
    test_latency();
    test_en_drop();
    test_err_inj();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
